// File: rtl/clarvi_soc_pio_pkg.sv
// Register map shared by the CLARVI SoC PIO blocks (LED output, button input).
package clarvi_soc_pio_pkg;

  localparam logic [2:0] PIO_ADDR_DATA     = 3'd0;
  localparam logic [2:0] PIO_ADDR_BLINK    = 3'd2;
  localparam logic [2:0] PIO_ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] PIO_ADDR_OUTCLEAR = 3'd5;

endpackage

// File: rtl/clarvi_soc_blink_prescaler.sv
// Free-running divider producing a square-wave phase with a half-period of DIV clocks;
// restart zeroes counter and phase on the same edge.
module clarvi_soc_blink_prescaler #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic phase
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == TERM) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/clarvi_soc_out_leds.sv
// Avalon-MM LED output PIO: DATA / OUTSET / OUTCLEAR registers, 1-cycle read latency.
// Optional blink engine enabled by defining CLARVI_SOC_OUT_LEDS_BLINK_EN.
module clarvi_soc_out_leds
  import clarvi_soc_pio_pkg::*;
#(
  parameter int          WIDTH       = 16,
  parameter logic [31:0] RESET_VALUE = '0,
  parameter int          BLINK_DIV   = 25_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [WIDTH-1:0] RST_DATA = RESET_VALUE[WIDTH-1:0];

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             unused_wd_hi;

  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];
  // Bits above WIDTH are architecturally ignored.
  assign unused_wd_hi = &{1'b0, writedata};

  always_comb begin
    data_d = data_q;
    if (wr) begin
      case (address)
        PIO_ADDR_DATA:     data_d = wd;
        PIO_ADDR_OUTSET:   data_d = data_q | wd;
        PIO_ADDR_OUTCLEAR: data_d = data_q & ~wd;
        default:           data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RST_DATA;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

`ifdef CLARVI_SOC_OUT_LEDS_BLINK_EN
  logic [WIDTH-1:0] blink_q, blink_d;
  logic             blink_wr;
  logic             phase;

  assign blink_wr = wr && (address == PIO_ADDR_BLINK);

  always_comb begin
    blink_d = blink_wr ? wd : blink_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blink_q <= '0;
    else          blink_q <= blink_d;
  end

  // A BLINK write restarts the prescaler so the first toggle is DIV cycles away.
  clarvi_soc_blink_prescaler #(.DIV(BLINK_DIV)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (blink_wr),
    .phase   (phase)
  );

  always_comb begin
    readdata_d = '0;
    case (address)
      PIO_ADDR_DATA:  readdata_d[WIDTH-1:0] = data_q;
      PIO_ADDR_BLINK: readdata_d[WIDTH-1:0] = blink_q;
      default:        readdata_d = '0;
    endcase
  end

  assign out_port = data_q ^ (blink_q & {WIDTH{phase}});
`else
  localparam int unused_blink_div = BLINK_DIV;

  always_comb begin
    readdata_d = '0;
    if (address == PIO_ADDR_DATA) readdata_d[WIDTH-1:0] = data_q;
  end

  assign out_port = data_q;
`endif

endmodule

// File: tb/tb_clarvi_soc_out_leds.sv
// Table-driven bench for clarvi_soc_out_leds with a readdata scoreboard queue.
module tb_clarvi_soc_out_leds;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [15:0] out_port;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [15:0] exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  clarvi_soc_out_leds #(
    .WIDTH(16), .RESET_VALUE(32'h0), .BLINK_DIV(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic cs, input logic wn, input logic [2:0] a,
                       input logic [31:0] wd, input logic [15:0] eo,
                       input logic [31:0] er, input string nm);
    @(negedge clk);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    exp_q.push_back(er);
    @(posedge clk);
    #1;
    check32({nm, " out_port"}, {16'h0, out_port}, {16'h0, eo});
    if (exp_q.size() == 0) check32({nm, " scoreboard empty"}, 32'h1, 32'h0);
    else                   check32({nm, " readdata"}, readdata, exp_q.pop_front());
  endtask

  task automatic reset_pulse(input string nm);
    #2;
    reset_n = 1'b0;
    #1;
    check32({nm, " out_port in reset"}, {16'h0, out_port}, 32'h0);
    check32({nm, " readdata in reset"}, readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // Bus activity while in reset must not disturb anything.
    chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    check32("reset out_port", {16'h0, out_port}, 32'h0);
    check32("reset readdata", readdata, 32'h0);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    reset_n = 1'b1;

    tbl[0]  = '{1'b0, 1'b1, 3'd0, 32'h0,         16'h0000, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 3'd0, 32'hFFFF_A5A5, 16'hA5A5, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 3'd0, 32'h0,         16'hA5A5, 32'h0000_A5A5};
    tbl[3]  = '{1'b0, 1'b0, 3'd0, 32'h1234,      16'hA5A5, 32'h0000_A5A5};
    tbl[4]  = '{1'b1, 1'b1, 3'd0, 32'h1234,      16'hA5A5, 32'h0000_A5A5};
    tbl[5]  = '{1'b1, 1'b0, 3'd4, 32'h000F,      16'hA5AF, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 3'd0, 32'h0,         16'hA5AF, 32'h0000_A5AF};
    tbl[7]  = '{1'b1, 1'b0, 3'd5, 32'h0081,      16'hA52E, 32'h0};
    tbl[8]  = '{1'b1, 1'b1, 3'd4, 32'h0,         16'hA52E, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 3'd5, 32'h0,         16'hA52E, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 3'd6, 32'hFFFF,      16'hA52E, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 3'd1, 32'hFFFF,      16'hA52E, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 3'd3, 32'hFFFF,      16'hA52E, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 3'd7, 32'hFFFF,      16'hA52E, 32'h0};
    tbl[14] = '{1'b1, 1'b1, 3'd0, 32'h0,         16'hA52E, 32'h0000_A52E};
    tbl[15] = '{1'b1, 1'b0, 3'd0, 32'hABCD_0000, 16'h0000, 32'h0000_A52E};
    tbl[16] = '{1'b1, 1'b1, 3'd0, 32'h0,         16'h0000, 32'h0};
    tbl[17] = '{1'b1, 1'b1, 3'd6, 32'h0,         16'h0000, 32'h0};

    for (int i = 0; i < NV; i++)
      apply(tbl[i].cs, tbl[i].wn, tbl[i].addr, tbl[i].wd, tbl[i].exp_out,
            tbl[i].exp_rd, $sformatf("vec%0d", i));

`ifdef CLARVI_SOC_OUT_LEDS_BLINK_EN
    // BLINK=3 over DATA=0; DATA becomes 1 at step 12, which does not restart the blink.
    for (int k = 0; k < 20; k++) begin
      logic [15:0] d;
      logic [15:0] eo;
      d  = (k >= 12) ? 16'h0001 : 16'h0000;
      eo = d ^ ((((k / 4) % 2) == 1) ? 16'h0003 : 16'h0000);
      if (k == 0)       apply(1'b1, 1'b0, 3'd2, 32'h0003, eo, 32'h0, $sformatf("blink%0d", k));
      else if (k == 12) apply(1'b1, 1'b0, 3'd0, 32'h0001, eo, 32'h0, $sformatf("blink%0d", k));
      else              apply(1'b1, 1'b1, 3'd2, 32'h0, eo, 32'h0000_0003, $sformatf("blink%0d", k));
    end
    reset_pulse("midblink");
    for (int k = 0; k < 8; k++) begin
      logic [15:0] eo;
      eo = (k >= 4) ? 16'h0001 : 16'h0000;
      if (k == 0) apply(1'b1, 1'b0, 3'd2, 32'h0001, eo, 32'h0, $sformatf("restart%0d", k));
      else        apply(1'b1, 1'b1, 3'd2, 32'h0, eo, 32'h0000_0001, $sformatf("restart%0d", k));
    end
`else
    apply(1'b1, 1'b0, 3'd0, 32'h1234, 16'h1234, 32'h0,         "nb data");
    apply(1'b1, 1'b0, 3'd2, 32'hFFFF, 16'h1234, 32'h0,         "nb wr2");
    apply(1'b1, 1'b1, 3'd2, 32'h0,    16'h1234, 32'h0,         "nb rd2");
    apply(1'b1, 1'b1, 3'd0, 32'h0,    16'h1234, 32'h0000_1234, "nb rd0");
    reset_pulse("async");
    apply(1'b1, 1'b1, 3'd0, 32'h0,    16'h0000, 32'h0,         "post reset");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
